// File: rtl/ex_div_unit_if.sv
// Handshake bundle between the ID/EX operand path, the EX-stage divider and the hazard unit.
// The divider is the slave: it receives operands and returns the stall request and result.
interface ex_div_unit_if #(
  parameter int XLEN = 32
) ();
  logic            StartE;
  logic [1:0]      DivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            KillE;
  logic            DivStallE;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  modport master (
    output StartE, DivOpE, SrcAE, SrcBE, KillE,
    input  DivStallE, DivDoneE, DivResultE
  );

  modport slave (
    input  StartE, DivOpE, SrcAE, SrcBE, KillE,
    output DivStallE, DivDoneE, DivResultE
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider: one restoring step per cycle on magnitudes, sign fix-up into a result register.
// Zero-divisor and signed-overflow cases complete combinationally in IDLE without stalling.
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_div_unit_if.slave  div_if
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      op_q, op_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;

  logic            stall, done;
  logic [XLEN-1:0] result_out;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Operand classification in IDLE; KillE suppresses both the start and the fast path.
  logic            is_signed;
  logic            start_ok;
  logic            div_zero;
  logic            sovf;
  logic            special;
  logic signed [XLEN-1:0] src_a_s, src_b_s;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    src_a_s   = $signed(div_if.SrcAE);
    src_b_s   = $signed(div_if.SrcBE);
    is_signed = ~div_if.DivOpE[0];
    start_ok  = div_if.StartE & ~div_if.KillE;
    div_zero  = (div_if.SrcBE == '0);
    sovf      = is_signed && (src_a_s == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_s == -1);
    special   = start_ok & (div_zero | sovf);
    if (div_zero) begin
      spec_res = div_if.DivOpE[1] ? div_if.SrcAE : '1;
    end else begin
      spec_res = div_if.DivOpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Restoring step: the 33-bit compare/subtract keeps the shifted-out MSB.
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] step_rem, step_quo;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, dvsr_q});
    rem_sub  = rem_sh - {1'b0, dvsr_q};
    step_rem = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], rem_ge};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    op_d       = op_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    stall      = 1'b0;
    done       = 1'b0;
    result_out = result_q;

    unique case (state_q)
      IDLE: begin
        if (special) begin
          done       = 1'b1;
          result_out = spec_res;
        end else if (start_ok) begin
          stall   = 1'b1;
          state_d = CALC;
          count_d = 5'd31;
          rem_d   = '0;
          quo_d   = cond_neg(div_if.SrcAE, is_signed & div_if.SrcAE[XLEN-1]);
          dvsr_d  = cond_neg(div_if.SrcBE, is_signed & div_if.SrcBE[XLEN-1]);
          op_d    = div_if.DivOpE;
          qsign_d = is_signed & (div_if.SrcAE[XLEN-1] ^ div_if.SrcBE[XLEN-1]);
          rsign_d = is_signed & div_if.SrcAE[XLEN-1];
        end
      end
      CALC: begin
        stall = 1'b1;
        if (div_if.KillE) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q - 5'd1;
          if (count_q == 5'd0) begin
            state_d  = DONE;
            result_d = op_q[1] ? cond_neg(step_rem, rsign_q) : cond_neg(step_quo, qsign_q);
          end
        end
      end
      DONE: begin
        done    = ~div_if.KillE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      op_q     <= op_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
    end
  end

  assign div_if.DivStallE  = stall;
  assign div_if.DivDoneE   = done;
  assign div_if.DivResultE = result_out;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: expected results are queued at issue and checked when DivDoneE fires.
module tb_ex_div_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] sb_q[$];

  ex_div_unit_if #(.XLEN(32)) div_if ();

  ex_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V divide semantics computed with native operators.
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int stalls);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    stalls = 33;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      stalls = 0;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
      stalls = 0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    res = op[1] ? r : q;
  endtask

  task automatic idle();
    div_if.StartE = 1'b0;
    div_if.KillE  = 1'b0;
    #1;
    check_eq("idle_stall", 32'(div_if.DivStallE), 32'd0);
    check_eq("idle_done", 32'(div_if.DivDoneE), 32'd0);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the done cycle so a new op can follow directly.
  task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall,
                        input bit perturb);
    int stalls;
    bit got;
    div_if.StartE = 1'b1;
    div_if.KillE  = 1'b0;
    div_if.DivOpE = op;
    div_if.SrcAE  = a;
    div_if.SrcBE  = b;
    sb_q.push_back(exp_res);
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (perturb && c == 5) begin
        div_if.SrcAE = $urandom;
        div_if.SrcBE = $urandom;
      end
      #1;
      if (div_if.DivDoneE) begin
        got = 1'b1;
        check_eq({tag, "_res"}, div_if.DivResultE, sb_q.pop_front());
        check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
        check_eq({tag, "_stall_at_done"}, 32'(div_if.DivStallE), 32'd0);
      end else if (div_if.DivStallE) begin
        stalls++;
      end
      @(negedge clk);
    end
    if (!got) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rres;
    logic [1:0]  rop;
    int          rst_cnt, dones;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    div_if.StartE = 1'b0;
    div_if.KillE  = 1'b0;
    div_if.DivOpE = 2'b00;
    div_if.SrcAE  = '0;
    div_if.SrcBE  = '0;
    #12;
    check_eq("rst_stall", 32'(div_if.DivStallE), 32'd0);
    check_eq("rst_done", 32'(div_if.DivDoneE), 32'd0);
    check_eq("rst_result", div_if.DivResultE, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_div("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b0);        idle();
    do_div("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0);         idle();
    do_div("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0); idle();
    do_div("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0); idle();
    do_div("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 1'b0); idle();
    do_div("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 1'b0); idle();
    do_div("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 1'b0); idle();

    do_div("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);       idle();
    do_div("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 0, 1'b0);              idle();
    do_div("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0); idle();
    do_div("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0); idle();

    // KillE beats StartE in IDLE, even on a fast-path operand pair.
    div_if.StartE = 1'b1;
    div_if.KillE  = 1'b1;
    div_if.DivOpE = 2'b00;
    div_if.SrcAE  = 32'd5;
    div_if.SrcBE  = 32'd0;
    #1;
    check_eq("kill_idle_done", 32'(div_if.DivDoneE), 32'd0);
    check_eq("kill_idle_stall", 32'(div_if.DivStallE), 32'd0);
    @(negedge clk);
    idle();

    // Kill in mid-CALC.
    div_if.StartE = 1'b1;
    div_if.DivOpE = 2'b01;
    div_if.SrcAE  = 32'hFFFF_FFFF;
    div_if.SrcBE  = 32'd1;
    repeat (11) @(negedge clk);
    div_if.KillE = 1'b1;
    @(posedge clk);
    #1;
    check_eq("kill_calc_stall", 32'(div_if.DivStallE), 32'd0);
    check_eq("kill_calc_done", 32'(div_if.DivDoneE), 32'd0);
    @(negedge clk);
    div_if.StartE = 1'b0;
    div_if.KillE  = 1'b0;
    dones = 0;
    repeat (36) begin
      #1;
      if (div_if.DivDoneE) dones++;
      @(negedge clk);
    end
    check_eq("kill_no_done", 32'(dones), 32'd0);
    do_div("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0);            idle();

    // Asynchronous reset in mid-CALC.
    div_if.StartE = 1'b1;
    div_if.DivOpE = 2'b01;
    div_if.SrcAE  = 32'd1000;
    div_if.SrcBE  = 32'd3;
    repeat (21) @(negedge clk);
    div_if.StartE = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_stall", 32'(div_if.DivStallE), 32'd0);
    check_eq("arst_done", 32'(div_if.DivDoneE), 32'd0);
    check_eq("arst_result", div_if.DivResultE, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rst_cnt = 0;
    repeat (36) begin
      #1;
      if (div_if.DivDoneE || div_if.DivStallE) rst_cnt++;
      @(negedge clk);
    end
    check_eq("arst_quiet", 32'(rst_cnt), 32'd0);

    do_div("divu_perturb", 2'b01, 32'd1000, 32'd10, 32'd100, 33, 1'b1);   idle();

    // Back-to-back: second start in the IDLE cycle right after the first DONE.
    do_div("b2b_50_5", 2'b01, 32'd50, 32'd5, 32'd10, 33, 1'b0);
    do_div("b2b_81_9", 2'b01, 32'd81, 32'd9, 32'd9, 33, 1'b0);
    idle();

    for (int i = 0; i < 8; i++) begin
      int es;
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rop = 2'($urandom_range(0, 3));
      ref_model(rop, ra, rb, rres, es);
      do_div($sformatf("rand%0d", i), rop, ra, rb, rres, es, 1'b0);
      idle();
    end

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
